// File: rtl/fft2_feeder.sv
// Source side of a radix-2 butterfly: buffers the first half of each 2L block and pairs x[k] with x[k+L].
// Optional FFT2_TW_CONJ_EN: conjugate the twiddle here for inverse blocks and drive ifft low.
module fft2_feeder #(
    parameter int N     = 28,
    parameter int LOG2L = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic                 in_sof,
    input  logic [2*N-1:0]       in_data,
    input  logic                 ifft_in,
    output logic [LOG2L-1:0]     tw_addr,
    input  logic [31:0]          tw_data,
    output logic                 out_vld,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [2*N-1:0]       data0,
    output logic [2*N-1:0]       data1,
    output logic [31:0]          w1,
    output logic                 ifft
);

    localparam int L = 1 << LOG2L;
    localparam logic [LOG2L-1:0] KMAX = '1;

    typedef enum logic {FILL, PAIR} state_t;

    state_t            state_q, state_d;
    logic [LOG2L-1:0]  k_q, k_d;
    logic              blk_ifft_q, blk_ifft_d;
    logic [2*N-1:0]    buf_q [L];
    logic              buf_we;
    logic [LOG2L-1:0]  buf_waddr;
    logic              go_p0;

    logic              vld_p1_q, sof_p1_q, eof_p1_q, ifft_p1_q;
    logic [2*N-1:0]    d0_p1_q, d1_p1_q;

    logic [31:0]       w1_d;
    logic              ifft_d;

    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        return (v == 16'sh8000) ? 16'sh7FFF : -v;
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        blk_ifft_d = blk_ifft_q;
        buf_we     = 1'b0;
        buf_waddr  = k_q;
        go_p0      = 1'b0;
        if (in_vld) begin
            if (in_sof) begin
                buf_we     = 1'b1;
                buf_waddr  = '0;
                k_d        = LOG2L'(1);
                state_d    = FILL;
                blk_ifft_d = ifft_in;
            end else if (state_q == FILL) begin
                buf_we = 1'b1;
                if (k_q == '0) blk_ifft_d = ifft_in;
                k_d = k_q + 1'b1;
                if (k_q == KMAX) state_d = PAIR;
            end else begin
                go_p0 = 1'b1;
                k_d   = k_q + 1'b1;
                if (k_q == KMAX) state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            k_q        <= '0;
            blk_ifft_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            blk_ifft_q <= blk_ifft_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[buf_waddr] <= in_data;
    end

    // Stage 1: read x[k], capture x[k+L], present the twiddle address
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            sof_p1_q  <= 1'b0;
            eof_p1_q  <= 1'b0;
            ifft_p1_q <= 1'b0;
            tw_addr   <= '0;
        end else begin
            vld_p1_q <= go_p0;
            if (go_p0) begin
                sof_p1_q  <= (k_q == '0);
                eof_p1_q  <= (k_q == KMAX);
                ifft_p1_q <= blk_ifft_q;
                tw_addr   <= k_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (go_p0) begin
            d0_p1_q <= buf_q[k_q];
            d1_p1_q <= in_data;
        end
    end

    always_comb begin
        w1_d   = tw_data;
        ifft_d = ifft_p1_q;
`ifdef FFT2_TW_CONJ_EN
        ifft_d = 1'b0;
        if (ifft_p1_q) w1_d = {tw_data[31:16], neg_sat(tw_data[15:0])};
`endif
    end

    // Stage 2: butterfly-facing outputs; payload holds across gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_sof <= 1'b0;
            out_eof <= 1'b0;
            data0   <= '0;
            data1   <= '0;
            w1      <= '0;
            ifft    <= 1'b0;
        end else begin
            out_vld <= vld_p1_q;
            out_sof <= vld_p1_q & sof_p1_q;
            out_eof <= vld_p1_q & eof_p1_q;
            if (vld_p1_q) begin
                data0 <= d0_p1_q;
                data1 <= d1_p1_q;
                w1    <= w1_d;
                ifft  <= ifft_d;
            end
        end
    end

endmodule

// File: tb/tb_fft2_feeder.sv
// Table-driven bench for fft2_feeder: per-cycle stimulus rows with hand-derived expected outputs.
module tb_fft2_feeder;

    localparam int N = 28;
    localparam int LOG2L = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_vld = 1'b0, in_sof = 1'b0, ifft_in = 1'b0;
    logic [2*N-1:0]   in_data = '0;
    logic [LOG2L-1:0] tw_addr;
    logic [31:0]      tw_data;
    logic             out_vld, out_sof, out_eof, ifft;
    logic [2*N-1:0]   data0, data1;
    logic [31:0]      w1;
    logic             rom_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    fft2_feeder #(.N(N), .LOG2L(LOG2L)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data),
        .ifft_in(ifft_in), .tw_addr(tw_addr), .tw_data(tw_data), .out_vld(out_vld),
        .out_sof(out_sof), .out_eof(out_eof), .data0(data0), .data1(data1), .w1(w1), .ifft(ifft)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (rom_mode) tw_data = 32'h2D41_8000;
        else          tw_data = {16'h4000, 12'h000, tw_addr};
    end

    typedef struct {
        logic rst, vld, sof, ifi, rom;
        logic [2*N-1:0] din;
        logic ev, es, ee, ei;
        logic [2*N-1:0] e0, e1;
        logic [31:0] ew;
    } vec_t;

    vec_t tbl[$];
    logic [2*N-1:0] h0 = '0, h1 = '0, p0 = '0, p1 = '0;
    logic [31:0] hw = '0, pw = '0;
    logic hi = 1'b0, pv = 1'b0, ps = 1'b0, pe = 1'b0, pi = 1'b0;

    function automatic logic [2*N-1:0] smp(input int n);
        logic [N-1:0] re, im;
        re = N'(n);
        im = N'(-n);
        return {re, im};
    endfunction

    function automatic logic [31:0] expw(input int k, input logic fi, input logic rom);
        logic [31:0] raw;
        raw = rom ? 32'h2D41_8000 : {16'h4000, 16'(k)};
`ifdef FFT2_TW_CONJ_EN
        if (fi) raw[15:0] = (raw[15:0] == 16'h8000) ? 16'h7FFF : 16'(-raw[15:0]);
`endif
        return raw;
    endfunction

    function automatic logic expi(input logic fi);
`ifdef FFT2_TW_CONJ_EN
        return 1'b0;
`else
        return fi;
`endif
    endfunction

    // Row expects the pair produced by the previous row's sample; n* is what this row's sample produces.
    task automatic push(input logic vld, sof, ifi, rom, input logic [2*N-1:0] din,
                        input logic nv, ns, ne, ni, input logic [2*N-1:0] n0, n1, input logic [31:0] nw);
        vec_t v;
        if (pv) begin h0 = p0; h1 = p1; hw = pw; hi = pi; end
        v.rst = 1'b0; v.vld = vld; v.sof = sof; v.ifi = ifi; v.rom = rom; v.din = din;
        v.ev = pv; v.es = pv & ps; v.ee = pv & pe; v.ei = hi;
        v.e0 = h0; v.e1 = h1; v.ew = hw;
        tbl.push_back(v);
        pv = nv; ps = ns; pe = ne; pi = ni; p0 = n0; p1 = n1; pw = nw;
    endtask

    task automatic push_rst();
        vec_t v;
        h0 = '0; h1 = '0; hw = '0; hi = 1'b0; pv = 1'b0;
        v.rst = 1'b1; v.vld = 1'b0; v.sof = 1'b0; v.ifi = 1'b0; v.rom = 1'b0; v.din = '0;
        v.ev = 1'b0; v.es = 1'b0; v.ee = 1'b0; v.ei = 1'b0;
        v.e0 = '0; v.e1 = '0; v.ew = '0;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic rom);
        push(1'b0, 1'b0, 1'b0, rom, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // ifft_in is inverted on all but the first sample of a block, so only the first may be latched
    task automatic stream(input int nsamp, input bit gaps, input bit [1:0] ifp, input int base,
                          input bit sof1, input bit rom, input bit tail);
        for (int j = 0; j < nsamp; j++) begin
            int pos, b, k;
            logic fi, drv;
            pos = j % 32; b = j / 32; k = pos - 16;
            fi = ifp[b];
            drv = (pos == 0) ? fi : ~fi;
            if (pos >= 16)
                push(1'b1, (j == 0) && sof1, drv, rom, smp(base + j), 1'b1, k == 0, k == 15, expi(fi),
                     smp(base + 32*b + k), smp(base + 32*b + 16 + k), expw(k, fi, rom));
            else
                push(1'b1, (j == 0) && sof1, drv, rom, smp(base + j), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            if (gaps) idle(rom);
        end
        if (tail) begin idle(rom); idle(rom); end
    endtask

    initial begin
        vec_t v;
        int lat;

        push_rst(); push_rst();
        stream(32, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b1);      // continuous block
        stream(32, 1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b1);      // every other cycle idle
        stream(64, 1'b0, 2'b10, 100, 1'b0, 1'b0, 1'b1);    // A forward, B inverse, back to back
        stream(20, 1'b0, 2'b00, 300, 1'b0, 1'b0, 1'b0);    // aborted at sample 20
        stream(32, 1'b0, 2'b01, 200, 1'b1, 1'b0, 1'b1);    // restart with in_sof
        stream(24, 1'b0, 2'b00, 400, 1'b0, 1'b0, 1'b0);    // reset lands at PAIR k=8
        push_rst();
        stream(32, 1'b0, 2'b01, 500, 1'b0, 1'b0, 1'b1);
        stream(32, 1'b0, 2'b01, 600, 1'b0, 1'b1, 1'b1);    // boundary twiddle im = -32768

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            rst = v.rst; in_vld = v.vld; in_sof = v.sof; in_data = v.din;
            ifft_in = v.ifi; rom_mode = v.rom;
            @(posedge clk); #1;
            checks++;
            if (out_vld !== v.ev) begin
                errors++;
                $display("FAIL vld row %0d: got %b want %b", r, out_vld, v.ev);
            end
            checks++;
            if ({out_sof, out_eof} !== {v.es, v.ee}) begin
                errors++;
                $display("FAIL sof_eof row %0d: got %b%b want %b%b", r, out_sof, out_eof, v.es, v.ee);
            end
            checks++;
            if ({data0, data1, w1, ifft} !== {v.e0, v.e1, v.ew, v.ei}) begin
                errors++;
                $display("FAIL pair row %0d: got d0=%h d1=%h w1=%h ifft=%b want d0=%h d1=%h w1=%h ifft=%b",
                         r, data0, data1, w1, ifft, v.e0, v.e1, v.ew, v.ei);
            end
            if (v.rst) begin
                checks++;
                if (tw_addr !== '0) begin
                    errors++;
                    $display("FAIL tw_addr_rst row %0d: got %h want 0", r, tw_addr);
                end
            end
        end

        // Latency: sample L after a fresh reset must show out_vld exactly two cycles later
        rst = 1'b1; in_vld = 1'b0; in_sof = 1'b0; rom_mode = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            in_vld = 1'b1; in_data = smp(700 + j);
            @(posedge clk); #1;
        end
        in_data = smp(716);
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_vld = 1'b0;
            lat++;
        end while (!out_vld && lat < 10);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles want 2", lat);
        end
        checks++;
        if ({data0, data1, out_sof} !== {smp(700), smp(716), 1'b1}) begin
            errors++;
            $display("FAIL latency_pair: got d0=%h d1=%h sof=%b want d0=%h d1=%h sof=1",
                     data0, data1, out_sof, smp(700), smp(716));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
